// File: rtl/progress_disp.sv
// Display-side renderer for record/playback progress: LED bar with blinking
// leading LED or a playback chaser, plus a 4-digit multiplexed 7-seg readout.
module progress_disp #(
    parameter int unsigned MAX_STEP  = 20,
    parameter int unsigned NLED      = 8,
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      menu,
    input  logic [5:0]      i,
    output logic [NLED-1:0] led,
    output logic [3:0]      an,
    output logic [6:0]      seg,
    output logic            dp
);

    localparam int unsigned LIT_W   = $clog2(NLED + 1);
    localparam int unsigned PROD_W  = 6 + LIT_W;
    localparam int unsigned POS_W   = (NLED > 1) ? $clog2(NLED) : 1;
    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REC  = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;
    localparam logic [1:0] S_PLAY = 2'd3;

    localparam logic [1:0] M_REC  = 2'b01;
    localparam logic [1:0] M_PLAY = 2'b10;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_Y     = 7'b0010001;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [5:0]           i_q, i_prev_q;
    logic [1:0]           state_q, state_d;
    logic [BLINK_W-1:0]   bcnt_q, bcnt_d;
    logic                 phase_q, phase_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [SCAN_W-1:0]    scnt_q, scnt_d;
    logic [1:0]           sel_q, sel_d;
    logic [NLED-1:0]      led_q, led_d;
    logic [3:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;

    logic [5:0]           i_c;
    logic                 step_c;
    logic                 bwrap_c;
    logic [PROD_W-1:0]    prod_c;
    logic [LIT_W-1:0]     lit_c;
    logic [3:0]           tens_c, units_c;

    function automatic logic [6:0] digit_code(input logic [3:0] d);
        case (d)
            4'd0:    digit_code = 7'b1000000;
            4'd1:    digit_code = 7'b1111001;
            4'd2:    digit_code = 7'b0100100;
            4'd3:    digit_code = 7'b0110000;
            4'd4:    digit_code = 7'b0011001;
            4'd5:    digit_code = 7'b0010010;
            4'd6:    digit_code = 7'b0000010;
            4'd7:    digit_code = 7'b1111000;
            4'd8:    digit_code = 7'b0000000;
            4'd9:    digit_code = 7'b0010000;
            default: digit_code = SEG_BLANK;
        endcase
    endfunction

    // Clamp, step detect and bar length derived from the registered index
    assign i_c     = (i_q > 6'(MAX_STEP)) ? 6'(MAX_STEP) : i_q;
    assign step_c  = (i_q != i_prev_q);
    assign bwrap_c = (bcnt_q == BLINK_W'(BLINK_DIV - 1));
    assign prod_c  = PROD_W'(i_c) * PROD_W'(NLED);
    assign lit_c   = LIT_W'(prod_c / PROD_W'(MAX_STEP));
    assign tens_c  = 4'(i_c / 6'd10);
    assign units_c = 4'(i_c % 6'd10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q      <= '0;
            i_prev_q <= '0;
            state_q  <= S_IDLE;
            bcnt_q   <= '0;
            phase_q  <= 1'b0;
            pos_q    <= '0;
            scnt_q   <= '0;
            sel_q    <= '0;
            led_q    <= '0;
            an_q     <= 4'b1111;
            seg_q    <= SEG_BLANK;
        end else begin
            i_q      <= i;
            i_prev_q <= i_q;
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            phase_q  <= phase_d;
            pos_q    <= pos_d;
            scnt_q   <= scnt_d;
            sel_q    <= sel_d;
            led_q    <= led_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q + BLINK_W'(1);
        phase_d = phase_q;
        pos_d   = '0;
        scnt_d  = scnt_q + SCAN_W'(1);
        sel_d   = sel_q;
        led_d   = '0;
        an_d    = ~(4'b1000 >> sel_q);
        seg_d   = SEG_BLANK;

        // menu=11 falls through every arm as "not record, not play"
        case (state_q)
            S_IDLE: begin
                if (menu == M_REC)       state_d = S_REC;
                else if (menu == M_PLAY) state_d = S_PLAY;
            end
            S_REC: begin
                if (menu != M_REC)                  state_d = S_IDLE;
                else if (i_c == 6'(MAX_STEP))       state_d = S_FULL;
            end
            S_FULL: begin
                if (menu != M_REC)                  state_d = S_IDLE;
                else if (i_c < 6'(MAX_STEP))        state_d = S_REC;
            end
            default: begin
                if (menu != M_PLAY)                 state_d = S_IDLE;
            end
        endcase

        // A fresh step restarts the blink with the leading LED lit
        if (step_c) begin
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (bwrap_c) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end

        if (state_q == S_PLAY) begin
            pos_d = pos_q;
            if (!step_c && bwrap_c)
                pos_d = (pos_q == POS_W'(NLED - 1)) ? '0 : pos_q + POS_W'(1);
        end

        if (scnt_q == SCAN_W'(SCAN_DIV - 1)) begin
            scnt_d = '0;
            sel_d  = sel_q + 2'd1;
        end

        case (state_q)
            S_IDLE: led_d = '0;
            S_REC: begin
                led_d = (NLED'(1) << lit_c) - NLED'(1);
                if (lit_c < LIT_W'(NLED))
                    led_d = led_d | (NLED'(phase_q) << lit_c);
            end
            S_FULL:  led_d = {NLED{phase_q}};
            default: led_d = NLED'(1) << pos_q;
        endcase

        // Slot 0 is the leftmost digit (an[3])
        case (state_q)
            S_IDLE: seg_d = SEG_DASH;
            S_REC: begin
                case (sel_q)
                    2'd0:    seg_d = SEG_R;
                    2'd1:    seg_d = SEG_BLANK;
                    2'd2:    seg_d = (tens_c == 4'd0) ? SEG_BLANK : digit_code(tens_c);
                    default: seg_d = digit_code(units_c);
                endcase
            end
            S_FULL: begin
                case (sel_q)
                    2'd0:    seg_d = SEG_F;
                    2'd1:    seg_d = SEG_U;
                    default: seg_d = SEG_L;
                endcase
            end
            default: begin
                case (sel_q)
                    2'd0:    seg_d = SEG_P;
                    2'd1:    seg_d = SEG_L;
                    2'd2:    seg_d = SEG_A;
                    default: seg_d = SEG_Y;
                endcase
            end
        endcase
    end

    assign led = led_q;
    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_progress_disp.sv
// Self-checking bench for progress_disp: directed and random menu/index
// sequences compared cycle by cycle against a behavioural display model.
module tb_progress_disp;

    localparam int MAX_STEP  = 20;
    localparam int NLED      = 8;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] menu  = 2'b00;
    logic [5:0] i_in  = 6'd0;
    logic [7:0] led;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_cmp  = 0;
    int n_fail = 0;

    // model: 0 idle, 1 record, 2 full, 3 play
    int         m_iq, m_iqd, m_state, m_bcnt, m_phase, m_pos, m_scnt, m_sel;
    logic [7:0] m_led;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    progress_disp #(
        .MAX_STEP (MAX_STEP),
        .NLED     (NLED),
        .SCAN_DIV (SCAN_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .menu (menu),
        .i    (i_in),
        .led  (led),
        .an   (an),
        .seg  (seg),
        .dp   (dp)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] char_code(input byte c);
        case (c)
            "0": char_code = 7'b1000000;
            "1": char_code = 7'b1111001;
            "2": char_code = 7'b0100100;
            "3": char_code = 7'b0110000;
            "4": char_code = 7'b0011001;
            "5": char_code = 7'b0010010;
            "6": char_code = 7'b0000010;
            "7": char_code = 7'b1111000;
            "8": char_code = 7'b0000000;
            "9": char_code = 7'b0010000;
            "-": char_code = 7'b0111111;
            "r": char_code = 7'b0101111;
            "P": char_code = 7'b0001100;
            "L": char_code = 7'b1000111;
            "A": char_code = 7'b0001000;
            "Y": char_code = 7'b0010001;
            "F": char_code = 7'b0001110;
            "U": char_code = 7'b1000001;
            default: char_code = 7'b1111111;
        endcase
    endfunction

    function automatic string disp_text(input int st, input int ic);
        case (st)
            0: disp_text = "----";
            1: disp_text = (ic >= 10) ? $sformatf("r %0d", ic) : $sformatf("r  %0d", ic);
            2: disp_text = "FULL";
            default: disp_text = "PLAY";
        endcase
    endfunction

    task automatic model_reset();
        m_iq = 0; m_iqd = 0; m_state = 0; m_bcnt = 0; m_phase = 0;
        m_pos = 0; m_scnt = 0; m_sel = 0;
        m_led = 8'h00; m_an = 4'hF; m_seg = 7'h7F;
    endtask

    // Advance the model by one clock using the inputs present at that edge
    task automatic model_step();
        int    ic, lit, nstate, bar;
        bit    step, wrap;
        string txt;
        ic   = (m_iq > MAX_STEP) ? MAX_STEP : m_iq;
        step = (m_iq != m_iqd);
        wrap = !step && (m_bcnt == BLINK_DIV - 1);

        case (m_state)
            0: m_led = 8'h00;
            1: begin
                lit = ic * NLED / MAX_STEP;
                bar = (1 << lit) - 1;
                if (lit < NLED && m_phase != 0) bar = bar + (1 << lit);
                m_led = 8'(bar);
            end
            2: m_led = (m_phase != 0) ? 8'hFF : 8'h00;
            default: m_led = 8'(1 << m_pos);
        endcase

        txt   = disp_text(m_state, ic);
        m_seg = char_code(txt[m_sel]);
        m_an  = 4'hF;
        m_an[3 - m_sel] = 1'b0;

        nstate = m_state;
        case (m_state)
            0: nstate = (menu == 2'b01) ? 1 : (menu == 2'b10) ? 3 : 0;
            1: nstate = (menu != 2'b01) ? 0 : (ic == MAX_STEP) ? 2 : 1;
            2: nstate = (menu != 2'b01) ? 0 : (ic < MAX_STEP) ? 1 : 2;
            default: nstate = (menu != 2'b10) ? 0 : 3;
        endcase

        m_pos = (m_state == 3) ? (wrap ? (m_pos + 1) % NLED : m_pos) : 0;

        if (step) begin
            m_bcnt = 0; m_phase = 1;
        end else if (m_bcnt == BLINK_DIV - 1) begin
            m_bcnt = 0; m_phase = 1 - m_phase;
        end else begin
            m_bcnt = m_bcnt + 1;
        end

        if (m_scnt == SCAN_DIV - 1) begin
            m_scnt = 0; m_sel = (m_sel + 1) % 4;
        end else begin
            m_scnt = m_scnt + 1;
        end

        m_state = nstate;
        m_iqd   = m_iq;
        m_iq    = int'(i_in);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("led", 32'(led), 32'(m_led));
        chk("an",  32'(an),  32'(m_an));
        chk("seg", 32'(seg), 32'(m_seg));
        chk("dp",  32'(dp),  32'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Asynchronous reset pulse taken away from the clock edge
    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_all();
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all();
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(10);

        // Record ramp 0..10, then hold to watch the leading LED blink
        menu = 2'b01;
        for (int k = 0; k <= 10; k++) begin
            i_in = 6'(k);
            run(3);
        end
        run(40);

        // Reset in the middle of recording
        pulse_reset();
        run(12);

        // Full, clamped over-range, then back below full
        for (int k = 11; k <= 20; k++) begin
            i_in = 6'(k);
            run(2);
        end
        run(30);
        i_in = 6'd35;
        run(24);
        i_in = 6'd19;
        run(30);

        // Step landing on the same edge as a blink wrap
        for (int k = 0; k < 20 && m_bcnt != BLINK_DIV - 2; k++) tick();
        i_in = 6'd18;
        run(12);

        // Leave record mid-way
        menu = 2'b00;
        run(10);

        // Playback chaser past a full wrap, then reserved menu code
        menu = 2'b10;
        run(80);
        menu = 2'b11;
        run(10);
        menu = 2'b10;
        run(20);
        menu = 2'b01;
        i_in = 6'd5;
        run(10);

        // Random menu / index traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 49) == 0) menu = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 2) == 0) i_in = 6'($urandom_range(0, 40));
                else if (i_in < 6'd40)         i_in = i_in + 6'd1;
            end
            tick();
            if ($urandom_range(0, 999) == 0) pulse_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
